// File: rtl/sbox_arbiter_pkg.sv
// Shared constants for the S-box arbiter: datapath byte width, the legal
// requester-count range and the width of an encoded requester index.
package sbox_arbiter_pkg;

  localparam int BYTE_W    = 8;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant picker: the search starts one past last_grant and wraps,
// returning a one-hot grant, its encoded index and a grant-present flag.
module rr_grant
  import sbox_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int cand;

  // First requester found after last_grant (modulo N_REQ) wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant) + k) % N_REQ;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one external combinational S-box between N_REQ requesters. One
// request is granted per cycle round-robin; its S-box result is captured into
// a per-lane result register that the requester must consume before it can
// be granted again.
module sbox_arbiter
  import sbox_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]        req_encrypt,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [BYTE_W*N_REQ-1:0] rsp_byte,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [BYTE_W-1:0]       sb_byte,
  output logic                    sb_encrypt,
  input  logic [BYTE_W-1:0]       sb_result,
  output logic                    busy
);

  // After reset the highest lane counts as last served, so lane 0 goes first.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic             grant_any;

  // A lane holding an unconsumed result is never eligible; nothing is
  // granted while reset is asserted.
  assign eligible  = rst ? '0 : (req_valid & ~rsp_valid);
  assign req_ready = grant;
  assign busy      = |rsp_valid;

  rr_grant #(
    .N_REQ (N_REQ)
  ) u_rr_grant (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Steer the granted lane onto the shared S-box; idle drives zero.
  always_comb begin
    sb_byte    = '0;
    sb_encrypt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sb_byte    = req_byte[BYTE_W*i +: BYTE_W];
        sb_encrypt = req_encrypt[i];
      end
    end
  end

  // Capture stage: grant edge loads the result, consume edge clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_byte   <= '0;
      last_grant <= LAST_RST;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i]                   <= 1'b1;
          rsp_byte[BYTE_W*i +: BYTE_W]   <= sb_result;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i]                   <= 1'b0;
        end
      end
    end
  end

endmodule
